// File: rtl/word_queue_pkg.sv
// rtl/word_queue_pkg.sv - shared defaults and pointer-width helper for word_queue
package word_queue_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int DEPTH_DEFAULT = 4;

  // DEPTH is a power of two >= 2, so this is exactly the index width
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/word_queue_ptr.sv
// rtl/word_queue_ptr.sv - wrapping queue pointer with increment and synchronous clear
module word_queue_ptr
  import word_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        inc,
  input  logic                        clr,
  output logic [ptr_width(DEPTH)-1:0] ptr
);

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0] r_ptr;

  // clr wins over inc so a flush in the same cycle as a transfer lands on 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/word_queue.sv
// rtl/word_queue.sv - single-clock word FIFO with flush and explicit occupancy counter
module word_queue
  import word_queue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_enq_valid,
  output logic                      io_enq_ready,
  input  logic [WIDTH-1:0]          io_enq_bits,
  output logic                      io_deq_valid,
  input  logic                      io_deq_ready,
  output logic [WIDTH-1:0]          io_deq_bits,
  input  logic                      io_flush,
  output logic [ptr_width(DEPTH):0] io_count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_rd_ptr;
  logic [PW-1:0]    w_wr_ptr;
  logic             w_enq;
  logic             w_deq;

  // Ready/valid come only from the registered count: no full bypass, no enq-to-deq path
  assign io_enq_ready = (r_count < CW'(DEPTH));
  assign io_deq_valid = (r_count != '0);
  assign w_enq        = io_enq_valid & io_enq_ready & ~io_flush;
  assign w_deq        = io_deq_valid & io_deq_ready & ~io_flush;
  assign io_deq_bits  = r_mem[w_rd_ptr];
  assign io_count     = r_count;

  word_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (w_deq),
    .clr   (io_flush),
    .ptr   (w_rd_ptr)
  );

  word_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (w_enq),
    .clr   (io_flush),
    .ptr   (w_wr_ptr)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enq) begin
      r_mem[w_wr_ptr] <= io_enq_bits;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (io_flush) begin
      r_count <= '0;
    end else begin
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_word_queue.sv
// tb/tb_word_queue.sv - directed and randomized bench for word_queue against a queue model
module tb_word_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             io_enq_valid = 1'b0;
  logic             io_enq_ready;
  logic [WIDTH-1:0] io_enq_bits = '0;
  logic             io_deq_valid;
  logic             io_deq_ready = 1'b0;
  logic [WIDTH-1:0] io_deq_bits;
  logic             io_flush = 1'b0;
  logic [2:0]       io_count;

  int n_pass  = 0;
  int n_total = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] out_q[$];

  word_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_enq_valid (io_enq_valid),
    .io_enq_ready (io_enq_ready),
    .io_enq_bits  (io_enq_bits),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_flush     (io_flush),
    .io_count     (io_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 64'(io_count), 64'(model_q.size()));
    check({tag, "_deq_valid"}, 64'(io_deq_valid), 64'(model_q.size() > 0));
    check({tag, "_enq_ready"}, 64'(io_enq_ready), 64'(model_q.size() < DEPTH));
    if (model_q.size() > 0) check({tag, "_head"}, 64'(io_deq_bits), 64'(model_q[0]));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare
  task automatic cycle(input logic ev, input logic [WIDTH-1:0] eb, input logic dr,
                       input logic fl, input string tag);
    bit do_enq, do_deq;
    io_enq_valid = ev;
    io_enq_bits  = eb;
    io_deq_ready = dr;
    io_flush     = fl;
    do_enq = ev && (model_q.size() < DEPTH) && !fl;
    do_deq = dr && (model_q.size() > 0) && !fl;
    if (io_deq_valid && dr && !fl) out_q.push_back(io_deq_bits);
    @(posedge clock);
    #1;
    if (fl) model_q.delete();
    else begin
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(eb);
    end
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b0;
    io_flush     = 1'b0;
    check_state(tag);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    model_q.delete();
    out_q.delete();
    reset = 1'b1;
  endtask

  initial begin
    // Reset held low across edges
    #12;
    check("rst_count", 64'(io_count), 64'd0);
    check("rst_enq_ready", 64'(io_enq_ready), 64'd1);
    check("rst_deq_valid", 64'(io_deq_valid), 64'd0);
    check("rst_deq_bits", 64'(io_deq_bits), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Single word
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, "single");
    check("single_bits", 64'(io_deq_bits), 64'hDEADBEEF);
    check("single_count", 64'(io_count), 64'd1);

    // Fill past full, then drain
    pulse_reset();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b0, 1'b0, "fill");
      if (i == 4) check("fill_ready_after4", 64'(io_enq_ready), 64'd0);
    end
    check("fill_count", 64'(io_count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_word", 64'(io_deq_bits), 64'(i));
      cycle(1'b0, '0, 1'b1, 1'b0, "drain");
    end
    check("drain_empty", 64'(io_deq_valid), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, "deq_empty");

    // Simultaneous enqueue and dequeue at count 2
    pulse_reset();
    cycle(1'b1, 32'h11, 1'b0, 1'b0, "sim_pre");
    cycle(1'b1, 32'h22, 1'b0, 1'b0, "sim_pre");
    cycle(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, "sim_both");
    check("sim_count", 64'(io_count), 64'd2);
    check("sim_head", 64'(io_deq_bits), 64'h22);
    cycle(1'b0, '0, 1'b1, 1'b0, "sim_pop");
    check("sim_new_word", 64'(io_deq_bits), 64'hA5A5A5A5);

    // Streaming wrap-around
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, WIDTH'(32'h10 + i), 1'b1, 1'b0, "wrap");
      check("wrap_count_le1", 64'(io_count <= 3'd1), 64'd1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, "wrap_tail");
    check("wrap_out_len", 64'(out_q.size()), 64'd10);
    for (int i = 0; i < 10 && i < out_q.size(); i++)
      check("wrap_order", 64'(out_q[i]), 64'(32'h10 + i));

    // Flush overrides an enqueue
    pulse_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(32'h30 + i), 1'b0, 1'b0, "fl_pre");
    cycle(1'b1, 32'h99, 1'b0, 1'b1, "flush");
    check("flush_count", 64'(io_count), 64'd0);
    check("flush_deq_valid", 64'(io_deq_valid), 64'd0);
    cycle(1'b1, 32'h55, 1'b0, 1'b0, "post_flush");
    check("post_flush_head", 64'(io_deq_bits), 64'h55);

    // Asynchronous reset mid-cycle
    pulse_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(32'h40 + i), 1'b0, 1'b0, "ar_pre");
    #2;
    reset = 1'b0;
    #1;
    check("async_count", 64'(io_count), 64'd0);
    check("async_deq_valid", 64'(io_deq_valid), 64'd0);
    model_q.delete();
    out_q.delete();
    reset = 1'b1;
    cycle(1'b1, 32'h77, 1'b0, 1'b0, "post_async");
    check("post_async_head", 64'(io_deq_bits), 64'h77);
    cycle(1'b0, '0, 1'b1, 1'b0, "post_async_pop");
    check("post_async_out", 64'(out_q.size() == 1 && out_q[0] == 32'h77), 64'd1);

    // Randomized traffic with occasional flushes
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 6), WIDTH'($urandom), ($urandom_range(0, 9) < 5),
            ($urandom_range(0, 31) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
